// File: rtl/rtr_bus_sched_if.sv
// Router internal-bus bundle: terminal FIFO status/heads in, grant, packet and push/pop strobes out.
interface rtr_bus_sched_if #(parameter int PCKG_SZ = 40);
    logic [3:0]           pndng_i;
    logic [4*PCKG_SZ-1:0] data_out_i;
    logic [7:0]           dest_i;
    logic [3:0]           dst_full;
    logic [1:0]           trn;
    logic [PCKG_SZ-1:0]   data_in_i;
    logic [3:0]           push_o;
    logic [3:0]           pop_i;
    logic                 busy;
    logic                 err;

    modport master (
        input  pndng_i, data_out_i, dest_i, dst_full,
        output trn, data_in_i, push_o, pop_i, busy, err
    );

    modport slave (
        output pndng_i, data_out_i, dest_i, dst_full,
        input  trn, data_in_i, push_o, pop_i, busy, err
    );
endinterface

// File: rtl/rtr_bus_sched.sv
// Round-robin scheduler for a 4-terminal router bus: grant, wait for room at the destination, move one packet.
module rtr_bus_sched #(
    parameter int PCKG_SZ = 40,
    parameter int N_PORTS = 4
) (
    input  logic           clk,
    input  logic           rst,
    rtr_bus_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, XFER = 2'd2} state_t;

    state_t             state, state_nx;
    logic [1:0]         ptr, ptr_nx, trn_q, trn_nx, dst_q, dst_nx, sel;
    logic [PCKG_SZ-1:0] data_q, data_nx;
    logic               err_q, err_nx;

    // First pending terminal at or after ptr, wrapping.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        sel   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = ptr + 2'(k);
            if (!found && bus.pndng_i[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        trn_nx   = trn_q;
        dst_nx   = dst_q;
        data_nx  = data_q;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.pndng_i) begin
                    state_nx = HOLD;
                    trn_nx   = sel;
                    data_nx  = bus.data_out_i[int'(sel)*PCKG_SZ +: PCKG_SZ];
                    dst_nx   = bus.dest_i[{sel, 1'b0} +: 2];
                end
            end
            HOLD: begin
                if (!bus.pndng_i[trn_q]) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                    ptr_nx   = trn_q + 2'd1;
                end else if (!bus.dst_full[dst_q]) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                state_nx = IDLE;
                ptr_nx   = trn_q + 2'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            trn_q  <= '0;
            dst_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            trn_q  <= trn_nx;
            dst_q  <= dst_nx;
            data_q <= data_nx;
            err_q  <= err_nx;
        end
    end

    // Strobes decode from state only, so reset kills them the instant it asserts.
    assign bus.push_o    = (state == XFER) ? (4'b0001 << dst_q) : 4'b0000;
    assign bus.pop_i     = (state == XFER) ? (4'b0001 << trn_q) : 4'b0000;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;
    assign bus.trn       = trn_q;
    assign bus.data_in_i = data_q;
endmodule

// File: tb/tb_rtr_bus_sched.sv
// Directed bench for rtr_bus_sched: transaction-level model checked every cycle plus literal scenario checks.
module tb_rtr_bus_sched;
    localparam int PCKG_SZ = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rtr_bus_sched_if #(.PCKG_SZ(PCKG_SZ)) bus ();

    rtr_bus_sched #(.PCKG_SZ(PCKG_SZ), .N_PORTS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: phase 0 = waiting, 1 = granted/waiting for room, 2 = moving.
    function automatic int pick(input logic [3:0] p, input int from);
        for (int k = 0; k < 4; k++)
            if (p[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    int                 m_ph, m_ptr, m_trn, m_dst;
    logic [PCKG_SZ-1:0] m_data;
    logic               m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_ptr <= 0; m_trn <= 0; m_dst <= 0; m_data <= '0; m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_ph == 0) begin
                if (pick(bus.pndng_i, m_ptr) >= 0) begin
                    m_trn  <= pick(bus.pndng_i, m_ptr);
                    m_data <= bus.data_out_i[pick(bus.pndng_i, m_ptr)*PCKG_SZ +: PCKG_SZ];
                    m_dst  <= int'(bus.dest_i[2*pick(bus.pndng_i, m_ptr) +: 2]);
                    m_ph   <= 1;
                end
            end else if (m_ph == 1) begin
                if (!bus.pndng_i[m_trn]) begin
                    m_ph <= 0; m_err <= 1'b1; m_ptr <= (m_trn + 1) % 4;
                end else if (!bus.dst_full[m_dst]) begin
                    m_ph <= 2;
                end
            end else begin
                m_ph <= 0; m_ptr <= (m_trn + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_trn",  64'(bus.trn), 64'(m_trn));
        chk("m_data", 64'(bus.data_in_i), 64'(m_data));
        chk("m_push", 64'(bus.push_o), (m_ph == 2) ? 64'(1) << m_dst : 64'd0);
        chk("m_pop",  64'(bus.pop_i),  (m_ph == 2) ? 64'(1) << m_trn : 64'd0);
        chk("m_busy", 64'(bus.busy), 64'(m_ph != 0));
        chk("m_err",  64'(bus.err), 64'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pndng_i  = '0;
        bus.dst_full = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    int glog[$];
    int gcyc[$];
    logic [PCKG_SZ-1:0] pkt0;

    initial begin
        bus.pndng_i    = '0;
        bus.dst_full   = '0;
        bus.dest_i     = '0;
        bus.data_out_i = {40'h33_3333_3333, 40'h22_2222_2222, 40'h11_1111_1111, 40'h00_0000_00A0};
        pkt0 = 40'h00_0000_00A0;
        #1;
        chk("rst_trn",  64'(bus.trn), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_push", 64'(bus.push_o), 64'd0);
        do_reset();

        // Single source 2 to destination 1.
        bus.pndng_i = 4'b0100;
        bus.dest_i  = 8'h10;
        step();
        chk("a_trn", 64'(bus.trn), 64'd2);
        chk("a_busy", 64'(bus.busy), 64'd1);
        step();
        chk("a_push", 64'(bus.push_o), 64'h2);
        chk("a_pop",  64'(bus.pop_i), 64'h4);
        bus.pndng_i = 4'b0000;
        step();
        chk("a_idle", 64'(bus.busy), 64'd0);
        bus.pndng_i = 4'b1111;
        step();
        chk("a_ptr3", 64'(bus.trn), 64'd3);

        // All four pending from reset; terminal 3 loops back to itself.
        bus.dest_i = 8'b11_11_10_01;
        do_reset();
        bus.pndng_i = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            step();
            for (int j = 0; j < 4; j++)
                if (bus.pop_i[j]) begin glog.push_back(j); gcyc.push_back(c); end
        end
        chk("b_cnt", 64'(glog.size()), 64'd5);
        for (int k = 0; k < 5 && k < glog.size(); k++) begin
            chk("b_order", 64'(glog[k]), 64'(k % 4));
            chk("b_cycle", 64'(gcyc[k]), 64'(3 * k + 2));
        end

        // Destination 3 full for five HOLD cycles; others churn meanwhile.
        do_reset();
        bus.pndng_i  = 4'b0001;
        bus.dest_i   = 8'h03;
        bus.dst_full = 4'b1000;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("c_busy", 64'(bus.busy), 64'd1);
            chk("c_push", 64'(bus.push_o), 64'd0);
            chk("c_data", 64'(bus.data_in_i), 64'(pkt0));
            bus.pndng_i = (c % 2 == 1) ? 4'b0111 : 4'b0001;
            bus.data_out_i[0 +: PCKG_SZ] = 40'h55_5555_5555;
        end
        bus.dst_full = 4'b0000;
        step();
        chk("c_xpush", 64'(bus.push_o), 64'h8);
        chk("c_xpop",  64'(bus.pop_i), 64'h1);
        chk("c_xdata", 64'(bus.data_in_i), 64'(pkt0));
        bus.pndng_i = 4'b0000;
        bus.data_out_i[0 +: PCKG_SZ] = pkt0;
        step();

        // Source 1 withdraws during HOLD; search resumes at 2.
        do_reset();
        bus.pndng_i = 4'b0010;
        bus.dest_i  = 8'h00;
        step();
        chk("d_trn", 64'(bus.trn), 64'd1);
        bus.pndng_i = 4'b1001;
        step();
        chk("d_err",  64'(bus.err), 64'd1);
        chk("d_push", 64'(bus.push_o), 64'd0);
        chk("d_pop",  64'(bus.pop_i), 64'd0);
        step();
        chk("d_err0", 64'(bus.err), 64'd0);
        chk("d_next", 64'(bus.trn), 64'd3);

        // Reset lands mid-transfer of 3 to 0.
        do_reset();
        bus.pndng_i = 4'b1000;
        bus.dest_i  = 8'h00;
        step();
        step();
        chk("e_pop", 64'(bus.pop_i), 64'h8);
        rst = 1'b1;
        #1;
        chk("e_rpop",  64'(bus.pop_i), 64'd0);
        chk("e_rpush", 64'(bus.push_o), 64'd0);
        chk("e_rbusy", 64'(bus.busy), 64'd0);
        chk("e_rtrn",  64'(bus.trn), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("e_regrant", 64'(bus.trn), 64'd3);
        do_reset();
        bus.pndng_i = 4'b1010;
        step();
        chk("e_prec", 64'(bus.trn), 64'd1);
        bus.pndng_i = 4'b0000;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
